// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: EXE_CMD encodings, FSM states, SR bit positions.
// Build option ALU_ARB_FIXED_PRIO_EN selects fixed port-0 priority in place of round-robin.
package alu_arb_pkg;

  localparam logic [3:0] MOV = 4'd1;
  localparam logic [3:0] ADD = 4'd2;
  localparam logic [3:0] ADC = 4'd3;
  localparam logic [3:0] SUB = 4'd4;
  localparam logic [3:0] SBC = 4'd5;
  localparam logic [3:0] AND = 4'd6;
  localparam logic [3:0] ORR = 4'd7;
  localparam logic [3:0] EOR = 4'd8;
  localparam logic [3:0] MVN = 4'd9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int SR_N = 3;
  localparam int SR_Z = 2;
  localparam int SR_C = 1;
  localparam int SR_V = 0;

endpackage

// File: rtl/alu_arb_rr_arb2.sv
// Two-way arbiter: round-robin with a priority pointer, or fixed port-0 priority
// when ALU_ARB_FIXED_PRIO_EN is defined (the pointer then does not exist).
module rr_arb2 (
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign gnt = {req[1] & ~req[0], req[0]};
`else
  logic ptr;

  always_comb begin
    gnt = 2'b00;
    if (!ptr) gnt = req[0] ? 2'b01 : {req[1], 1'b0};
    else      gnt = req[1] ? 2'b10 : {1'b0, req[0]};
  end

  // After a grant the pointer moves to the port that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ptr <= 1'b0;
    else if (advance && (|gnt))   ptr <= gnt[0];
  end
`endif

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between the EXE stage (port 0) and an auxiliary requester (port 1), owns SR.
// Build option ALU_ARB_FIXED_PRIO_EN gives port 0 fixed priority instead of round-robin.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CMD_W  = 4,
  parameter int ID_W   = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][CMD_W-1:0]  req_cmd,
  input  logic [1:0][DATA_W-1:0] req_val1,
  input  logic [1:0][DATA_W-1:0] req_val2,
  input  logic [1:0]             req_set_flags,
  input  logic [1:0][ID_W-1:0]   req_id,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_port,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DATA_W-1:0]      rsp_result,
  output logic [3:0]             rsp_status,
  output logic [DATA_W-1:0]      alu_val1,
  output logic [DATA_W-1:0]      alu_val2,
  output logic [CMD_W-1:0]       alu_exe_cmd,
  output logic [3:0]             alu_sr,
  input  logic [DATA_W-1:0]      alu_result,
  input  logic [3:0]             alu_status,
  input  logic                   sr_wr_en,
  input  logic [3:0]             sr_wr_data,
  output logic [3:0]             sr
);

  state_t state_q, state_d;
  logic [1:0] gnt;
  logic       accept;
  logic       gnt_port;

  logic              lat_set_flags;
  logic [ID_W-1:0]   lat_id;
  logic              lat_port;

  rr_arb2 u_arb (
`ifndef ALU_ARB_FIXED_PRIO_EN
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (state_q == IDLE),
`endif
    .req     (req_valid),
    .gnt     (gnt)
  );

  assign req_ready = (state_q == IDLE) ? gnt : 2'b00;
  assign accept    = |req_ready;
  assign gnt_port  = gnt[1];
  assign rsp_valid = (state_q == RESP);
  assign alu_sr    = sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands captured at accept feed the ALU directly for the single EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_exe_cmd   <= '0;
      alu_val1      <= '0;
      alu_val2      <= '0;
      lat_set_flags <= 1'b0;
      lat_id        <= '0;
      lat_port      <= 1'b0;
    end else if (accept) begin
      alu_exe_cmd   <= req_cmd[gnt_port];
      alu_val1      <= req_val1[gnt_port];
      alu_val2      <= req_val2[gnt_port];
      lat_set_flags <= req_set_flags[gnt_port];
      lat_id        <= req_id[gnt_port];
      lat_port      <= gnt_port;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= '0;
      rsp_status <= '0;
      rsp_id     <= '0;
      rsp_port   <= 1'b0;
    end else if (state_q == EXEC) begin
      rsp_result <= alu_result;
      rsp_status <= alu_status;
      rsp_id     <= lat_id;
      rsp_port   <= lat_port;
    end
  end

  // An explicit SR write always overrides a flag update from the finishing op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   sr <= 4'b0000;
    else if (sr_wr_en)                            sr <= sr_wr_data;
    else if ((state_q == EXEC) && lat_set_flags)  sr <= alu_status;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed vector table, hand-written corner sequences,
// then randomized traffic against a transaction-level model. Honours ALU_ARB_FIXED_PRIO_EN.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][3:0]   req_cmd;
  logic [1:0][31:0]  req_val1;
  logic [1:0][31:0]  req_val2;
  logic [1:0]        req_set_flags;
  logic [1:0][3:0]   req_id;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_port;
  logic [3:0]        rsp_id;
  logic [31:0]       rsp_result;
  logic [3:0]        rsp_status;
  logic [31:0]       alu_val1;
  logic [31:0]       alu_val2;
  logic [3:0]        alu_exe_cmd;
  logic [3:0]        alu_sr;
  logic [31:0]       alu_result;
  logic [3:0]        alu_status;
  logic              sr_wr_en;
  logic [3:0]        sr_wr_data;
  logic [3:0]        sr;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.DATA_W(32), .CMD_W(4), .ID_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
    .req_val1(req_val1), .req_val2(req_val2), .req_set_flags(req_set_flags),
    .req_id(req_id), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_port(rsp_port), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_status(rsp_status), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_exe_cmd(alu_exe_cmd), .alu_sr(alu_sr), .alu_result(alu_result),
    .alu_status(alu_status), .sr_wr_en(sr_wr_en), .sr_wr_data(sr_wr_data), .sr(sr)
  );

  // Behavioural ARM-style ALU: returns {N,Z,C,V, result}; carry on subtract means no borrow.
  function automatic logic [35:0] alu_ref(input logic [3:0] cmd, input logic [31:0] a,
                                          input logic [31:0] b, input logic [3:0] s);
    logic [32:0] w;
    logic [31:0] r;
    logic c, v;
    w = '0; c = 1'b0; v = 1'b0;
    case (cmd)
      MOV: r = b;
      MVN: r = ~b;
      AND: r = a & b;
      ORR: r = a | b;
      EOR: r = a ^ b;
      ADD, ADC: begin
        w = {1'b0, a} + {1'b0, b} + ((cmd == ADC) ? {32'd0, s[SR_C]} : 33'd0);
        r = w[31:0]; c = w[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      SUB, SBC: begin
        w = {1'b0, a} + {1'b0, ~b} + ((cmd == SUB) ? 33'd1 : {32'd0, s[SR_C]});
        r = w[31:0]; c = w[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      default: r = 32'd0;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  always_comb {alu_status, alu_result} = alu_ref(alu_exe_cmd, alu_val1, alu_val2, alu_sr);

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic doReset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 1'b0; sr_wr_en = 1'b0; sr_wr_data = 4'd0;
    req_cmd = '0; req_val1 = '0; req_val2 = '0; req_set_flags = '0; req_id = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  typedef struct {
    logic        port;
    logic [3:0]  cmd;
    logic [31:0] v1;
    logic [31:0] v2;
    logic        sf;
    logic [3:0]  preset;
    logic [3:0]  id;
    logic [31:0] expResult;
    logic [3:0]  expStatus;
    logic [3:0]  expSr;
  } vec_t;

  vec_t vecs[10];

  // One isolated transaction: preset SR, issue, and check latency, response and SR.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1 sr_wr_en = 1'b1; sr_wr_data = v.preset;
    @(posedge clk); #1 sr_wr_en = 1'b0; rsp_ready = 1'b1;
    req_valid = 2'b01 << v.port;
    req_cmd[v.port] = v.cmd; req_val1[v.port] = v.v1; req_val2[v.port] = v.v2;
    req_set_flags[v.port] = v.sf; req_id[v.port] = v.id;
    @(negedge clk); checkOutput("vec_req_ready", req_ready, 2'b01 << v.port);
    @(posedge clk); #1 req_valid = 2'b00;
    @(negedge clk); checkOutput("vec_exec_rsp_valid", rsp_valid, 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("vec_rsp_valid", rsp_valid, 1);
    checkOutput("vec_rsp_result", rsp_result, v.expResult);
    checkOutput("vec_rsp_status", rsp_status, v.expStatus);
    checkOutput("vec_rsp_port", rsp_port, v.port);
    checkOutput("vec_rsp_id", rsp_id, v.id);
    checkOutput("vec_sr", sr, v.expSr);
    @(posedge clk);
  endtask

  // Transaction-level model state for the random phase.
  logic        mBusy, mExec, mHave, mPref;
  logic        mPort, mSf;
  logic [3:0]  mCmd, mId, mSr;
  logic [31:0] mV1, mV2;
  logic [31:0] eResult;
  logic [3:0]  eStatus, eId;
  logic        ePort;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0]  expGnt;
    logic [35:0] ref36;
    logic [31:0] capResult;
    logic [3:0]  capId, capStatus;
    logic        capPort, got;
    int          nRsp;
    logic        rrExp[4];

    vecs[0] = '{1'b0, ADD, 32'hFFFF_FFFF, 32'h1,        1'b1, 4'b0000, 4'd3,  32'h0,         4'b0110, 4'b0110};
    vecs[1] = '{1'b0, MOV, 32'h0,         32'h8000_0000, 1'b0, 4'b0110, 4'd5,  32'h8000_0000, 4'b1000, 4'b0110};
    vecs[2] = '{1'b1, SUB, 32'h5,         32'h5,        1'b1, 4'b0000, 4'd9,  32'h0,         4'b0110, 4'b0110};
    vecs[3] = '{1'b1, ORR, 32'hF0,        32'h0F,       1'b1, 4'b1111, 4'd1,  32'hFF,        4'b0000, 4'b0000};
    vecs[4] = '{1'b0, EOR, 32'hF0,        32'hF0,       1'b0, 4'b0001, 4'd2,  32'h0,         4'b0100, 4'b0001};
    vecs[5] = '{1'b0, ADC, 32'h1,         32'h1,        1'b1, 4'b0010, 4'd7,  32'h3,         4'b0000, 4'b0000};
    vecs[6] = '{1'b1, SUB, 32'h8000_0000, 32'h1,        1'b1, 4'b0000, 4'd12, 32'h7FFF_FFFF, 4'b0011, 4'b0011};
    vecs[7] = '{1'b0, 4'hF, 32'h1234_5678, 32'h9,       1'b1, 4'b1000, 4'd14, 32'h0,         4'b0100, 4'b0100};
    vecs[8] = '{1'b1, MVN, 32'h0,         32'h0,        1'b0, 4'b0000, 4'd15, 32'hFFFF_FFFF, 4'b1000, 4'b0000};
    vecs[9] = '{1'b0, SBC, 32'h5,         32'h3,        1'b1, 4'b0000, 4'd4,  32'h1,         4'b0010, 4'b0010};

    doReset();
    @(negedge clk);
    checkOutput("reset_rsp_valid", rsp_valid, 0);
    checkOutput("reset_sr", sr, 0);
    checkOutput("reset_rsp_result", rsp_result, 0);
    checkOutput("reset_rsp_status", rsp_status, 0);
    checkOutput("reset_rsp_id", rsp_id, 0);
    checkOutput("reset_req_ready", req_ready, 0);

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

    // Both ports valid continuously: order of service after reset.
`ifdef ALU_ARB_FIXED_PRIO_EN
    rrExp = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    rrExp = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    doReset();
    @(posedge clk); #1
    req_valid = 2'b11; rsp_ready = 1'b1; req_cmd = {ADD, ADD};
    req_val1 = {32'd100, 32'd10}; req_val2 = {32'd1, 32'd2};
    req_set_flags = 2'b00; req_id = {4'hB, 4'hA};
    nRsp = 0;
    for (int c = 0; c < 40 && nRsp < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        checkOutput("rr_port", rsp_port, rrExp[nRsp]);
        checkOutput("rr_result", rsp_result, rsp_port ? 32'd101 : 32'd12);
        nRsp++;
      end
    end
    checkOutput("rr_count", nRsp, 4);

    // Backpressure with both requesters still asserting valid.
    @(posedge clk); #1 rsp_ready = 1'b0;
    got = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (rsp_valid) begin got = 1'b1; break; end
    end
    checkOutput("bp_rsp_seen", got, 1);
    capResult = rsp_result; capId = rsp_id; capPort = rsp_port; capStatus = rsp_status;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      checkOutput("bp_rsp_valid", rsp_valid, 1);
      checkOutput("bp_req_ready", req_ready, 0);
      checkOutput("bp_stable", {rsp_result, rsp_id, rsp_port, rsp_status}, {capResult, capId, capPort, capStatus});
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk); checkOutput("bp_no_same_cycle_accept", req_ready, 0);
    @(posedge clk);
    @(negedge clk); checkOutput("bp_resume", |req_ready, 1);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (4) @(posedge clk);

    // SR write collides with the flag update of a finishing SUB.
    #1 req_valid = 2'b01; req_cmd[0] = SUB; req_val1[0] = 32'd5; req_val2[0] = 32'd5;
    req_set_flags[0] = 1'b1; req_id[0] = 4'd6;
    @(posedge clk); #1 req_valid = 2'b00; sr_wr_en = 1'b1; sr_wr_data = 4'b1001;
    @(posedge clk); #1 sr_wr_en = 1'b0;
    @(negedge clk);
    checkOutput("conflict_sr", sr, 4'b1001);
    checkOutput("conflict_rsp_status", rsp_status, 4'b0110);
    checkOutput("conflict_rsp_valid", rsp_valid, 1);
    @(posedge clk);

    // Asynchronous reset while an op is in EXEC.
    @(posedge clk); #1 req_valid = 2'b01; req_cmd[0] = ADD; req_set_flags[0] = 1'b1;
    @(posedge clk); #1 req_valid = 2'b00;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_rsp_valid", rsp_valid, 0);
    checkOutput("midreset_sr", sr, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); checkOutput("midreset_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1 req_valid = 2'b10;
    @(negedge clk); checkOutput("midreset_idle", req_ready, 2'b10);
    @(posedge clk); #1 req_valid = 2'b00;
    repeat (3) @(posedge clk);

    // Randomized traffic against the transaction-level model.
    doReset();
    mBusy = 0; mExec = 0; mHave = 0; mPref = 0; mSr = 4'd0;
    mPort = 0; mSf = 0; mCmd = 0; mId = 0; mV1 = 0; mV2 = 0;
    eResult = 0; eStatus = 0; eId = 0; ePort = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      req_valid = 2'($urandom);
      for (int p = 0; p < 2; p++) begin
        req_cmd[p] = 4'($urandom_range(0, 15));
        req_val1[p] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        req_val2[p] = ($urandom_range(0, 3) == 0) ? 32'd1 : $urandom;
        req_set_flags[p] = 1'($urandom);
        req_id[p] = 4'($urandom);
      end
      rsp_ready = ($urandom_range(0, 9) < 7);
      sr_wr_en = ($urandom_range(0, 9) == 0);
      sr_wr_data = 4'($urandom);
      @(negedge clk);
      expGnt = 2'b00;
      if (!mBusy) begin
        if (req_valid == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
          expGnt = 2'b01;
`else
          expGnt = mPref ? 2'b10 : 2'b01;
`endif
        end else expGnt = req_valid;
      end
      checkOutput("rand_req_ready", req_ready, expGnt);
      checkOutput("rand_rsp_valid", rsp_valid, mHave);
      checkOutput("rand_sr", sr, mSr);
      checkOutput("rand_alu_sr", alu_sr, mSr);
      if (mHave) begin
        checkOutput("rand_rsp_result", rsp_result, eResult);
        checkOutput("rand_rsp_status", rsp_status, eStatus);
        checkOutput("rand_rsp_id", rsp_id, eId);
        checkOutput("rand_rsp_port", rsp_port, ePort);
      end
      if (mHave && rsp_ready) begin mHave = 0; mBusy = 0; end
      if (mExec) begin
        ref36 = alu_ref(mCmd, mV1, mV2, mSr);
        eResult = ref36[31:0]; eStatus = ref36[35:32]; eId = mId; ePort = mPort;
        mHave = 1; mExec = 0;
        if (mSf) mSr = eStatus;
      end
      if (sr_wr_en) mSr = sr_wr_data;
      if (expGnt != 2'b00) begin
        mPort = expGnt[1];
        mCmd = req_cmd[mPort]; mV1 = req_val1[mPort]; mV2 = req_val2[mPort];
        mSf = req_set_flags[mPort]; mId = req_id[mPort];
        mBusy = 1; mExec = 1; mPref = ~mPort;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
